encoder_frame_scheduler: RTL

- Sequences serial data into the LED-link encoder.
- Accepts 16-bit words from the host over a valid/ready handshake and emits them at symbol rate on reData, preceded by a preamble and followed by an idle gap.
- Drives balanceCLK so the encoder's idle detector sees activity only while symbols are being sent.
- Supplies the encoder's REF4Bits idle threshold from a static configuration input.

---
 rtl/enc_sched_pkg.sv | 9 +
 rtl/encoder_frame_scheduler_sym_tick_gen.sv | 20 ++
 rtl/encoder_frame_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/enc_sched_pkg.sv
// Shared types and default constants for the LED-link encoder frame scheduler.
package enc_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

  localparam int         DEF_SYM_DIV = 8;
  localparam logic [7:0] DEF_PRE_PAT = 8'hA5;
  localparam int         DEF_GAP_SYM = 4;
  localparam logic [3:0] REF_RESET   = 4'hF;
endpackage

// File: rtl/encoder_frame_scheduler_sym_tick_gen.sv
// Free-running symbol-rate divider; tick marks the last clk of each symbol.
module sym_tick_gen #(
  parameter int SYM_DIV = 8
) (
  input  logic clk,
  input  logic globalReset,
  output logic tick
);
  localparam int CW = $clog2(SYM_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SYM_DIV - 1));

  always_ff @(posedge clk) begin
    if (globalReset)  cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/encoder_frame_scheduler.sv
// Frames host words as preamble + payload + idle gap on reData at symbol rate,
// toggling balanceCLK on every symbol boundary while data flows.
module encoder_frame_scheduler
  import enc_sched_pkg::*;
#(
  parameter int                 SYM_DIV = DEF_SYM_DIV,
  parameter int                 WORD_W  = 16,
  parameter int                 PRE_LEN = 8,
  parameter logic [PRE_LEN-1:0] PRE_PAT = DEF_PRE_PAT,
  parameter int                 GAP_SYM = DEF_GAP_SYM
) (
  input  logic              clk,
  input  logic              globalReset,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              burst_en,
  input  logic [3:0]        ref_cfg,
  output logic [3:0]        REF4Bits,
  output logic              reData,
  output logic              balanceCLK,
  output logic              busy,
  output logic              word_done
);
  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int WW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GW = $clog2(GAP_SYM + 1);

  state_t            state;
  logic [PW-1:0]     pre_idx;
  logic [WW-1:0]     pay_idx;
  logic [GW-1:0]     gap_cnt;
  logic [WORD_W-1:0] shift;
  logic              pending;
  logic              tick;
  logic              accept;

  assign accept = word_valid && word_ready;

  sym_tick_gen #(.SYM_DIV(SYM_DIV)) u_tick (
    .clk         (clk),
    .globalReset (globalReset),
    .tick        (tick)
  );

  always_ff @(posedge clk) begin
    if (globalReset) begin
      state      <= S_IDLE;
      pre_idx    <= '0;
      pay_idx    <= '0;
      gap_cnt    <= '0;
      shift      <= '0;
      pending    <= 1'b0;
      word_ready <= 1'b0;
      reData     <= 1'b0;
      balanceCLK <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      REF4Bits   <= REF_RESET;
    end else begin
      word_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) REF4Bits <= ref_cfg;
          if (accept) begin
            shift   <= word_data;
            pending <= 1'b1;
          end
          if (tick && (pending || accept)) begin
            state      <= S_PRE;
            pre_idx    <= PW'(PRE_LEN - 1);
            reData     <= PRE_PAT[PRE_LEN-1];
            balanceCLK <= ~balanceCLK;
            busy       <= 1'b1;
            pending    <= 1'b0;
            word_ready <= 1'b0;
          end else begin
            word_ready <= !(pending || accept);
          end
        end
        S_PRE: begin
          if (tick) begin
            balanceCLK <= ~balanceCLK;
            if (pre_idx == '0) begin
              state   <= S_PAY;
              pay_idx <= WW'(WORD_W - 1);
              reData  <= shift[WORD_W-1];
            end else begin
              pre_idx <= pre_idx - 1'b1;
              reData  <= PRE_PAT[pre_idx - 1'b1];
            end
          end
        end
        S_PAY: begin
          // The last symbol's bit is already in reData, so a chained word may
          // overwrite the shift register as soon as it is accepted.
          if (accept) begin
            shift   <= word_data;
            pending <= 1'b1;
          end
          if (tick) begin
            if (pay_idx == '0) begin
              word_done  <= 1'b1;
              pending    <= 1'b0;
              word_ready <= 1'b0;
              if (pending || accept) begin
                pay_idx    <= WW'(WORD_W - 1);
                reData     <= accept ? word_data[WORD_W-1] : shift[WORD_W-1];
                balanceCLK <= ~balanceCLK;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
                reData  <= 1'b0;
              end
            end else begin
              pay_idx    <= pay_idx - 1'b1;
              reData     <= shift[pay_idx - 1'b1];
              balanceCLK <= ~balanceCLK;
              word_ready <= (pay_idx == WW'(1)) && burst_en;
            end
          end else begin
            word_ready <= (pay_idx == '0) && burst_en && !(pending || accept);
          end
        end
        S_GAP: begin
          word_ready <= 1'b0;
          if (tick) begin
            if (gap_cnt == GW'(GAP_SYM - 1)) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              word_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
